// File: rtl/bank_demux_2.sv
// Ping-pong write demux: steers an input word stream into two banks, one frame per bank,
// and hands a completed bank to the reader. Optional frame counter: BANK_DEMUX_FRAME_CNT_EN.
module bank_demux_2 #(
    parameter  int N     = 8,
    parameter  int DEPTH = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          a_we,
    output logic [AW-1:0] a_addr,
    output logic [N-1:0]  a_data,
    output logic          b_we,
    output logic [AW-1:0] b_addr,
    output logic [N-1:0]  b_data,
    input  logic          rd_done,
    output logic          rd_sel,
    output logic          rd_valid
`ifdef BANK_DEMUX_FRAME_CNT_EN
    ,
    output logic [15:0]   frame_cnt
`endif
);

    typedef enum logic {FILL = 1'b0, WAIT = 1'b1} state_t;

    state_t        r_state, w_state_nxt;
    logic          r_wr_bank;
    logic [AW-1:0] r_wr_addr;
    logic          r_rd_free;
    logic          r_rd_valid;
    logic          w_accept;
    logic          w_last;
    logic          w_reader_ok;
    logic          w_swap;

    assign w_accept    = in_valid && in_ready;
    assign w_last      = w_accept && (r_wr_addr == AW'(DEPTH - 1));
    assign w_reader_ok = r_rd_free || rd_done;

    always_comb begin
        w_state_nxt = r_state;
        w_swap      = 1'b0;
        in_ready    = 1'b0;
        case (r_state)
            FILL: begin
                in_ready = 1'b1;
                if (w_last) begin
                    if (w_reader_ok) w_swap      = 1'b1;
                    else             w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (w_reader_ok) begin
                    w_swap      = 1'b1;
                    w_state_nxt = FILL;
                end
            end
            default: w_state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= FILL;
            r_wr_bank  <= 1'b0;
            r_wr_addr  <= '0;
            r_rd_free  <= 1'b1;
            r_rd_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) r_wr_addr <= r_wr_addr + AW'(1);
            // A swap consumes any rd_done seen in the same cycle.
            if (w_swap) begin
                r_wr_bank  <= !r_wr_bank;
                r_rd_valid <= 1'b1;
                r_rd_free  <= 1'b0;
            end else if (rd_done) begin
                r_rd_free  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_we   <= 1'b0;
            a_addr <= '0;
            a_data <= '0;
            b_we   <= 1'b0;
            b_addr <= '0;
            b_data <= '0;
        end else begin
            a_we <= w_accept && !r_wr_bank;
            b_we <= w_accept &&  r_wr_bank;
            if (w_accept && !r_wr_bank) begin
                a_addr <= r_wr_addr;
                a_data <= in_data;
            end
            if (w_accept && r_wr_bank) begin
                b_addr <= r_wr_addr;
                b_data <= in_data;
            end
        end
    end

    assign rd_sel   = !r_wr_bank;
    assign rd_valid = r_rd_valid;

`ifdef BANK_DEMUX_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_frame_cnt <= '0;
        else if (w_swap) r_frame_cnt <= r_frame_cnt + 16'd1;
    end

    assign frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_bank_demux_2.sv
// Directed bench for bank_demux_2 (DEPTH=4, N=8): expected bank writes are queued at
// drive time and popped one cycle later when the write ports should show them.
module tb_bank_demux_2;
    localparam int N     = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          a_we, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [N-1:0]  a_data, b_data;
    logic          rd_done = 1'b0;
    logic          rd_sel;
    logic          rd_valid;
`ifdef BANK_DEMUX_FRAME_CNT_EN
    logic [15:0]   frame_cnt;
`endif

    bank_demux_2 #(.N(N), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .a_we(a_we), .a_addr(a_addr), .a_data(a_data),
        .b_we(b_we), .b_addr(b_addr), .b_data(b_data),
        .rd_done(rd_done), .rd_sel(rd_sel), .rd_valid(rd_valid)
`ifdef BANK_DEMUX_FRAME_CNT_EN
        , .frame_cnt(frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          bank;
        logic [AW-1:0] addr;
        logic [N-1:0]  data;
    } wr_t;

    wr_t q[$];
    int  total = 0;
    int  bad   = 0;

    // Behavioural expectation of the block, advanced once per driven cycle.
    logic          m_wait, m_bank, m_free, m_rdv;
    logic [AW-1:0] m_addr;
    int            m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wait = 1'b0; m_bank = 1'b0; m_free = 1'b1; m_rdv = 1'b0;
        m_addr = '0;   m_cnt  = 0;
        q.delete();
    endtask

    // One clock: check status, drive inputs, then check the write ports after the edge.
    task automatic cyc(input logic v, input logic [N-1:0] d, input logic done);
        logic acc, last, ok, sw;
        wr_t  e;
        chk("in_ready", {31'd0, in_ready}, {31'd0, !m_wait});
        chk("rd_sel",   {31'd0, rd_sel},   {31'd0, !m_bank});
        chk("rd_valid", {31'd0, rd_valid}, {31'd0, m_rdv});
        in_valid = v; in_data = d; rd_done = done;
        acc  = v && !m_wait;
        if (acc) q.push_back({m_bank, m_addr, d});
        last = acc && (m_addr == AW'(DEPTH - 1));
        ok   = m_free || done;
        sw   = (last || m_wait) && ok;
        if (!m_wait && last && !ok) m_wait = 1'b1;
        else if (sw)                m_wait = 1'b0;
        if (acc) m_addr = m_addr + AW'(1);
        if (sw) begin
            m_bank = !m_bank; m_rdv = 1'b1; m_free = 1'b0; m_cnt = (m_cnt + 1) % 65536;
        end else if (done) begin
            m_free = 1'b1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; rd_done = 1'b0;
        if (acc) begin
            e = q.pop_front();
            chk("a_we", {31'd0, a_we}, {31'd0, !e.bank});
            chk("b_we", {31'd0, b_we}, {31'd0, e.bank});
            chk("wr_addr", {30'd0, e.bank ? b_addr : a_addr}, {30'd0, e.addr});
            chk("wr_data", {24'd0, e.bank ? b_data : a_data}, {24'd0, e.data});
        end else begin
            chk("idle_we", {30'd0, a_we, b_we}, 32'd0);
        end
    endtask

    task automatic frame(input logic [N-1:0] base, input logic done_last);
        for (int i = 0; i < DEPTH; i++)
            cyc(1'b1, base + N'(i), (i == DEPTH - 1) ? done_last : 1'b0);
    endtask

    initial begin
        model_reset();
        #12;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_rd_sel",   {31'd0, rd_sel},   32'd1);
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_we",       {30'd0, a_we, b_we}, 32'd0);
        @(posedge clk); #1; rst_n = 1'b1;

        // Frame 1 into bank A; reader is free so it swaps with no stall.
        cyc(1'b1, 8'h11, 1'b0); cyc(1'b1, 8'h22, 1'b0);
        cyc(1'b1, 8'h33, 1'b0); cyc(1'b1, 8'h44, 1'b0);
        chk("f1_rd_sel",   {31'd0, rd_sel},   32'd0);
        chk("f1_rd_valid", {31'd0, rd_valid}, 32'd1);
        chk("f1_ready",    {31'd0, in_ready}, 32'd1);

        // Frame 2 into bank B with the reader busy: stall, held word not written.
        cyc(1'b1, 8'h55, 1'b0); cyc(1'b1, 8'h66, 1'b0);
        cyc(1'b1, 8'h77, 1'b0); cyc(1'b1, 8'h88, 1'b0);
        chk("f2_stall", {31'd0, in_ready}, 32'd0);
        cyc(1'b1, 8'h99, 1'b0);
        cyc(1'b1, 8'h99, 1'b1);
        chk("f2_resume_ready", {31'd0, in_ready}, 32'd1);
        chk("f2_resume_sel",   {31'd0, rd_sel},   32'd1);
        cyc(1'b1, 8'h99, 1'b0);
        chk("f3_first_a_addr", {30'd0, a_addr}, 32'd0);
        chk("f3_first_a_data", {24'd0, a_data}, 32'h99);

        // rd_done on the last word swaps with no WAIT; the following frame then stalls.
        cyc(1'b1, 8'hAA, 1'b0); cyc(1'b1, 8'hBB, 1'b0); cyc(1'b1, 8'hCC, 1'b1);
        chk("sim_no_wait", {31'd0, in_ready}, 32'd1);
        chk("sim_rd_sel",  {31'd0, rd_sel},   32'd0);
        frame(8'hD0, 1'b0);
        chk("f4_wait", {31'd0, in_ready}, 32'd0);
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b0);

        // Reset mid-frame discards the partial frame.
        cyc(1'b1, 8'hE0, 1'b0); cyc(1'b1, 8'hE1, 1'b0);
        rst_n = 1'b0; #1;
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_sel",   {31'd0, rd_sel},   32'd1);
        chk("mid_rst_we",    {30'd0, a_we, b_we}, 32'd0);
        model_reset();
        @(posedge clk); #1; rst_n = 1'b1;
        cyc(1'b1, 8'h5A, 1'b0);
        chk("post_rst_a_addr", {30'd0, a_addr}, 32'd0);
        chk("post_rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        cyc(1'b1, 8'h5B, 1'b0); cyc(1'b1, 8'h5C, 1'b0); cyc(1'b1, 8'h5D, 1'b0);
        frame(8'h60, 1'b1);
        frame(8'h70, 1'b1);
`ifdef BANK_DEMUX_FRAME_CNT_EN
        chk("frame_cnt_3", {16'd0, frame_cnt}, 32'd3);
        force dut.r_frame_cnt = 16'hFFFF;
        #1;
        release dut.r_frame_cnt;
        frame(8'h80, 1'b1);
        chk("frame_cnt_wrap", {16'd0, frame_cnt}, 32'd0);
`else
        frame(8'h80, 1'b1);
`endif
        chk("sb_empty", q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
